segment_transition_ctl: RTL
===========================

// Module: segment_transition_ctl
// PURPOSE
// Generic N-segment playback sequencer shared by the modulation and STM paths. Keeps the active segment and its sample index.
// Counts loops against the per-segment repeat count.
// Performs a requested segment switch when the selected transition condition fires: sync-index, sys-time, GPIO, ext auto-advance or immediate.
// Supersedes the fixed 2-segment swap logic.
// PARAMETERS
// NUM_SEGMENT     2   number of segments; SEG_W = $clog2(NUM_SEGMENT), min 1
// IDX_WIDTH       16  sample index / cycle width
// REP_WIDTH       16  repeat-count width; all-ones = infinite
// SYS_TIME_WIDTH  56  system time width
// NUM_GPIO        4   GPIO trigger inputs
// PORTS
// CLK               in   1                       system clock
// RST               in   1                       asynchronous reset, active-high
// TICK              in   1                       sample-advance strobe from the freq-div timer
// UPDATE            in   1                       1-cycle pulse; latch REQ_SEGMENT/MODE/VALUE
// REQ_SEGMENT       in   SEG_W                   requested segment
// TRANSITION_MODE   in   8                       transition_mode_t
// TRANSITION_VALUE  in   64                      sys time, or GPIO bit select in [1:0]
// CYCLE             in   NUM_SEGMENT*IDX_WIDTH   last index per segment (length-1)
// REP               in   NUM_SEGMENT*REP_WIDTH   loops-1 per segment
// SYS_TIME          in   SYS_TIME_WIDTH          synchronised system time
// GPIO_IN           in   NUM_GPIO                already-synchronised GPIO
// SEGMENT           out  SEG_W                   active segment
// IDX               out  IDX_WIDTH               current sample index
// STOP              out  1                       repeats exhausted; IDX frozen
// PENDING           out  1                       request latched, not yet applied
// SWITCHED          out  1                       1-cycle pulse, first cycle of the new segment
// REQ_ERR           out  1                       1-cycle pulse; REQ_SEGMENT >= NUM_SEGMENT, request dropped
// BEHAVIOUR
// - Reset: SEGMENT=0, IDX=0, STOP=0, PENDING=0, SWITCHED=0, REQ_ERR=0, loop_cnt=0, state RUN. RST mid-run clears all state immediately; no pending request survives.
// - States:
//   - RUN: TICK advances IDX. If IDX>=CYCLE[SEGMENT] at the tick, this is a wrap:
//     - REP all-ones, or loop_cnt<REP: IDX->0 and loop_cnt++.
//     - otherwise -> FINISHED with IDX held.
//   - FINISHED: STOP=1; TICK ignored.
//   - PENDING flag is orthogonal to RUN/FINISHED.
// - The IDX>=CYCLE compare covers CYCLE being shrunk below IDX mid-run; that case counts as a wrap.
// - UPDATE with a valid REQ_SEGMENT:
//   - Latches the request and sets PENDING=1 next cycle.
//   - A newer UPDATE replaces an older pending one.
//   - UPDATE wins over a trigger firing in the same cycle: the old request is discarded, not applied.
// - Trigger conditions, evaluated only on TICK cycles while PENDING:
//   - SYNC_IDX (00): the wrap tick of the current segment, or any tick while FINISHED.
//   - SYS_TIME (01): SYS_TIME >= VALUE[SYS_TIME_WIDTH-1:0] in the tick cycle (unsigned).
//   - GPIO (02): a rising edge of GPIO_IN[VALUE[1:0]] was seen since latch (sticky edge flag).
//   - IMMEDIATE (FF): the first tick after latch.
//   - EXT (F0): applies on the first tick like IMMEDIATE, then the block stays in ext mode.
//     - In ext mode, each finishing wrap (the point where RUN would enter FINISHED) instead advances SEGMENT=(SEGMENT+1) mod NUM_SEGMENT.
//     - Ext mode is left on the next UPDATE.
//   - Any other mode: treated as IMMEDIATE.
// - Switch latency: the trigger tick at cycle t gives SEGMENT=new, IDX=0, loop_cnt=0, STOP=0, PENDING=0 and SWITCHED=1 at cycle t+1.
// - Switching to the segment that is already active is legal: it restarts that segment.
// - Invalid REQ_SEGMENT: REQ_ERR pulses at t+1; any prior pending request is kept.
// - All outputs are registered; IDX reflects a TICK one cycle later.
// STRUCTURE
// - Additions to the params package:
//   - TRANSITION_MODE_IMMEDIATE = 8'hFF
//   - typedef enum {SEQ_RUN, SEQ_FINISHED} seq_state_t
//   - localparam REP_INFINITE = '1
// - One sub-module, transition_trigger, owns the latched mode/value, the GPIO edge-detect sticky flag and the SYS_TIME compare.
//   - Outputs fire (combinational on the registered state).
//   - Cleared on UPDATE or on switch.
// TESTING
// - CYCLE0=3, REP0=1, TICK every 4 clk -> IDX 0,1,2,3,0,1,2,3; STOP=1 after 8 ticks; IDX stays 3 on further ticks.
// - SEG0 CYCLE=9 looping; UPDATE SYNC_IDX to seg1 at IDX=4 -> PENDING=1; the switch happens on the tick after IDX=9; SEGMENT=1, IDX=0, SWITCHED pulse.
// - SYS_TIME mode with VALUE=1000: tick at SYS_TIME=999 gives no switch; the first tick with SYS_TIME>=1000 switches.
//   - Repeat with VALUE < current time: switches on the first tick.
// - GPIO mode with VALUE=2: GPIO_IN[2] pulses high between ticks -> switch on the next tick; GPIO_IN[1] activity is ignored.
// - NUM_SEGMENT=3, EXT, REP=0 all: segments cycle 0->1->2->0 at each wrap.
//   - UPDATE IMMEDIATE seg 1 mid-sequence -> ext mode is left.
//   - REQ_SEGMENT=3 -> REQ_ERR pulse, state unchanged.
// - UPDATE in the same cycle as a firing tick discards the old request; RST during PENDING -> all outputs at reset values, the request is lost.

Source files
------------

// File: rtl/segment_transition_ctl_pkg.sv
// Shared types and constants for the N-segment playback sequencer.
package segment_transition_ctl_pkg;

  typedef enum logic [7:0] {
    MODE_SYNC_IDX  = 8'h00,
    MODE_SYS_TIME  = 8'h01,
    MODE_GPIO      = 8'h02,
    MODE_EXT       = 8'hF0,
    MODE_IMMEDIATE = 8'hFF
  } transition_mode_t;

  localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

  typedef enum logic {
    SEQ_RUN,
    SEQ_FINISHED
  } seq_state_t;

  localparam logic [63:0] REP_INFINITE = '1;

endpackage

// File: rtl/segment_transition_ctl_transition_trigger.sv
// Holds the latched transition mode/value and decides when a pending switch may fire.
module transition_trigger
  import segment_transition_ctl_pkg::*;
#(
  parameter int SYS_TIME_WIDTH = 56,
  parameter int NUM_GPIO       = 4,
  localparam int GSEL_W        = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      latch_i,
  input  logic                      clear_i,
  input  logic [7:0]                mode_i,
  input  logic [SYS_TIME_WIDTH-1:0] value_i,
  input  logic [SYS_TIME_WIDTH-1:0] sys_time_i,
  input  logic [NUM_GPIO-1:0]       gpio_i,
  input  logic                      sync_point_i,
  output logic                      fire_o,
  output logic                      ext_mode_o
);

  logic [7:0]                mode_q;
  logic [SYS_TIME_WIDTH-1:0] value_q;
  logic [NUM_GPIO-1:0]       gpio_prev_q;
  logic                      edge_q, edge_d;
  logic [GSEL_W-1:0]         sel;
  logic                      rise;

  assign sel  = value_q[GSEL_W-1:0];
  assign rise = gpio_i[sel] & ~gpio_prev_q[sel];

  // Edge flag is sticky until the request is replaced or applied.
  assign edge_d = clear_i ? 1'b0 : (edge_q | rise);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q      <= '0;
      value_q     <= '0;
      gpio_prev_q <= '0;
      edge_q      <= 1'b0;
    end else begin
      gpio_prev_q <= gpio_i;
      edge_q      <= edge_d;
      if (latch_i) begin
        mode_q  <= mode_i;
        value_q <= value_i;
      end
    end
  end

  always_comb begin
    fire_o = 1'b1;
    case (mode_q)
      MODE_SYNC_IDX: fire_o = sync_point_i;
      MODE_SYS_TIME: fire_o = (sys_time_i >= value_q);
      MODE_GPIO:     fire_o = edge_q | rise;
      default:       fire_o = 1'b1;
    endcase
  end

  assign ext_mode_o = (mode_q == MODE_EXT);

endmodule

// File: rtl/segment_transition_ctl.sv
// N-segment playback sequencer: sample index, loop counting and triggered segment switching.
//   state        | meaning
//   SEQ_RUN      | TICK advances IDX, wraps count loops against REP
//   SEQ_FINISHED | repeats exhausted, IDX frozen, STOP high
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
#(
  parameter int NUM_SEGMENT    = 2,
  parameter int IDX_WIDTH      = 16,
  parameter int REP_WIDTH      = 16,
  parameter int SYS_TIME_WIDTH = 56,
  parameter int NUM_GPIO       = 4,
  localparam int SEG_W         = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             tick_i,
  input  logic                             update_i,
  input  logic [SEG_W-1:0]                 req_segment_i,
  input  logic [7:0]                       transition_mode_i,
  input  logic [63:0]                      transition_value_i,
  input  logic [NUM_SEGMENT*IDX_WIDTH-1:0] cycle_i,
  input  logic [NUM_SEGMENT*REP_WIDTH-1:0] rep_i,
  input  logic [SYS_TIME_WIDTH-1:0]        sys_time_i,
  input  logic [NUM_GPIO-1:0]              gpio_in_i,
  output logic [SEG_W-1:0]                 segment_o,
  output logic [IDX_WIDTH-1:0]             idx_o,
  output logic                             stop_o,
  output logic                             pending_o,
  output logic                             switched_o,
  output logic                             req_err_o
);

  seq_state_t           state_q, state_d;
  logic [SEG_W-1:0]     seg_q, seg_d, req_seg_q, req_seg_d, seg_next;
  logic [IDX_WIDTH-1:0] idx_q, idx_d, cycle_cur;
  logic [REP_WIDTH-1:0] loop_q, loop_d, rep_cur;
  logic                 pending_q, pending_d, ext_q, ext_d;
  logic                 switched_q, switched_d, req_err_q, req_err_d;
  logic                 req_ok, latch, wrap, sync_point, trig_fire, trig_ext, fire;

  assign cycle_cur  = cycle_i[32'(seg_q)*IDX_WIDTH +: IDX_WIDTH];
  assign rep_cur    = rep_i[32'(seg_q)*REP_WIDTH +: REP_WIDTH];
  assign seg_next   = (seg_q == SEG_W'(NUM_SEGMENT - 1)) ? '0 : seg_q + 1'b1;

  assign req_ok     = (32'(req_segment_i) < NUM_SEGMENT);
  assign latch      = update_i & req_ok;
  // >= rather than == so a CYCLE shrunk below the current index still wraps.
  assign wrap       = tick_i & (state_q == SEQ_RUN) & (idx_q >= cycle_cur);
  assign sync_point = wrap | (state_q == SEQ_FINISHED);
  // A fresh request discards the old one even if it would fire this cycle.
  assign fire       = pending_q & tick_i & trig_fire & ~latch;

  transition_trigger #(
    .SYS_TIME_WIDTH(SYS_TIME_WIDTH),
    .NUM_GPIO      (NUM_GPIO)
  ) u_trigger (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .latch_i     (latch),
    .clear_i     (latch | fire),
    .mode_i      (transition_mode_i),
    .value_i     (transition_value_i[SYS_TIME_WIDTH-1:0]),
    .sys_time_i  (sys_time_i),
    .gpio_i      (gpio_in_i),
    .sync_point_i(sync_point),
    .fire_o      (trig_fire),
    .ext_mode_o  (trig_ext)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SEQ_RUN;
      seg_q      <= '0;
      req_seg_q  <= '0;
      idx_q      <= '0;
      loop_q     <= '0;
      pending_q  <= 1'b0;
      ext_q      <= 1'b0;
      switched_q <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      req_seg_q  <= req_seg_d;
      idx_q      <= idx_d;
      loop_q     <= loop_d;
      pending_q  <= pending_d;
      ext_q      <= ext_d;
      switched_q <= switched_d;
      req_err_q  <= req_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    req_seg_d  = req_seg_q;
    idx_d      = idx_q;
    loop_d     = loop_q;
    pending_d  = pending_q;
    ext_d      = ext_q;
    switched_d = 1'b0;
    req_err_d  = update_i & ~req_ok;

    if (tick_i && state_q == SEQ_RUN) begin
      if (wrap) begin
        if (rep_cur == REP_INFINITE[REP_WIDTH-1:0] || loop_q < rep_cur) begin
          idx_d  = '0;
          loop_d = loop_q + 1'b1;
        end else if (ext_q) begin
          seg_d      = seg_next;
          idx_d      = '0;
          loop_d     = '0;
          switched_d = 1'b1;
        end else begin
          state_d = SEQ_FINISHED;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (fire) begin
      seg_d      = req_seg_q;
      idx_d      = '0;
      loop_d     = '0;
      state_d    = SEQ_RUN;
      pending_d  = 1'b0;
      switched_d = 1'b1;
      ext_d      = trig_ext;
    end

    if (latch) begin
      req_seg_d = req_segment_i;
      pending_d = 1'b1;
      ext_d     = 1'b0;
    end
  end

  assign segment_o  = seg_q;
  assign idx_o      = idx_q;
  assign stop_o     = (state_q == SEQ_FINISHED);
  assign pending_o  = pending_q;
  assign switched_o = switched_q;
  assign req_err_o  = req_err_q;

endmodule
